// File: rtl/dmem_unit_if.sv
// -----------------------------------------------------------------------------
// dmem_unit_if : datapath/controller bus of the filter data memory.
//   cmd_in  [2:0]      per-cycle memory command from the controller
//   addr_in [AW-1:0]   word address
//   d_in    [DATABITS] write data from the datapath
//   ext_in  [DATABITS] external sample input
//   d_out   [DATABITS] registered read data back to the datapath
// Modports: master = controller/datapath side, slave = memory side.
// -----------------------------------------------------------------------------
interface dmem_unit_if #(
    parameter int unsigned DMEMSIZE = 16,
    parameter int unsigned DATABITS = 24
);
    localparam int unsigned AW = $clog2(DMEMSIZE);

    logic [2:0]          cmd_in;
    logic [AW-1:0]       addr_in;
    logic [DATABITS-1:0] d_in;
    logic [DATABITS-1:0] ext_in;
    logic [DATABITS-1:0] d_out;

    modport master (
        output cmd_in,
        output addr_in,
        output d_in,
        output ext_in,
        input  d_out
    );

    modport slave (
        input  cmd_in,
        input  addr_in,
        input  d_in,
        input  ext_in,
        output d_out
    );
endinterface

// File: rtl/dmem_unit.sv
// -----------------------------------------------------------------------------
// dmem_unit : flip-flop data memory of the filter datapath.
//   DMEMSIZE words of DATABITS bits. Per-cycle command: NOP, READ, WRITE,
//   LOADEXT (store ext_in) or SHIFT (delay line, ext_in enters word 0).
//   A serial scan chain threads every memory bit for test load/unload.
// Ports:
//   clk     clock, all state on the rising edge
//   rst     synchronous active-high reset (clears memory and d_out)
//   sde_in  scan enable, 1 = shift the scan chain, commands ignored
//   sd_in   scan serial input (enters mem[0][0])
//   sd_out  scan serial output (mem[DMEMSIZE-1][DATABITS-1])
//   bus     dmem_unit_if slave: cmd_in, addr_in, d_in, ext_in, d_out
// -----------------------------------------------------------------------------
module dmem_unit #(
    parameter int unsigned DMEMSIZE = 16,
    parameter int unsigned DATABITS = 24
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        sde_in,
    input  logic        sd_in,
    output logic        sd_out,
    dmem_unit_if.slave  bus
);
    typedef enum logic [2:0] {
        CMD_NOP     = 3'd0,
        CMD_READ    = 3'd1,
        CMD_WRITE   = 3'd2,
        CMD_LOADEXT = 3'd3,
        CMD_SHIFT   = 3'd4
    } dmem_cmd_t;

    logic [DATABITS-1:0] mem_q [DMEMSIZE];
    logic [DATABITS-1:0] mem_d [DMEMSIZE];
    logic [DATABITS-1:0] dout_q;
    logic [DATABITS-1:0] dout_d;
    logic                addr_ok;

    // Only matters for non-power-of-2 sizes: out-of-range addresses are inert.
    assign addr_ok = (32'(bus.addr_in) < DMEMSIZE);

    // Next-state for memory array and read register.
    always_comb begin
        mem_d  = mem_q;
        dout_d = dout_q;
        if (sde_in) begin
            // Chain is {mem[N-1], ..., mem[0]}, shifting one bit toward the MSB.
            mem_d[0] = {mem_q[0][DATABITS-2:0], sd_in};
            for (int unsigned k = 1; k < DMEMSIZE; k++) begin
                mem_d[k] = {mem_q[k][DATABITS-2:0], mem_q[k-1][DATABITS-1]};
            end
        end else begin
            case (dmem_cmd_t'(bus.cmd_in))
                CMD_READ: begin
                    if (addr_ok) begin
                        dout_d = mem_q[bus.addr_in];
                    end else begin
                        dout_d = '0;
                    end
                end
                CMD_WRITE: begin
                    if (addr_ok) begin
                        mem_d[bus.addr_in] = bus.d_in;
                    end
                end
                CMD_LOADEXT: begin
                    if (addr_ok) begin
                        mem_d[bus.addr_in] = bus.ext_in;
                    end
                end
                CMD_SHIFT: begin
                    // Delay line: oldest sample in the top word falls off.
                    mem_d[0] = bus.ext_in;
                    for (int unsigned k = 1; k < DMEMSIZE; k++) begin
                        mem_d[k] = mem_q[k-1];
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // State registers; reset overrides scan and commands.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned k = 0; k < DMEMSIZE; k++) begin
                mem_q[k] <= '0;
            end
            dout_q <= '0;
        end else begin
            mem_q  <= mem_d;
            dout_q <= dout_d;
        end
    end

    assign bus.d_out = dout_q;
    assign sd_out    = mem_q[DMEMSIZE-1][DATABITS-1];
endmodule

// File: tb/tb_dmem_unit.sv
// -----------------------------------------------------------------------------
// tb_dmem_unit : directed self-checking bench for dmem_unit (16 x 24 bits).
// -----------------------------------------------------------------------------
module tb_dmem_unit;
    localparam int unsigned DMEMSIZE = 16;
    localparam int unsigned DATABITS = 24;
    localparam int unsigned AW       = 4;
    localparam int unsigned CHAIN    = DMEMSIZE * DATABITS;

    localparam logic [2:0] C_NOP     = 3'd0;
    localparam logic [2:0] C_READ    = 3'd1;
    localparam logic [2:0] C_WRITE   = 3'd2;
    localparam logic [2:0] C_LOADEXT = 3'd3;
    localparam logic [2:0] C_SHIFT   = 3'd4;

    logic clk = 1'b0;
    logic rst;
    logic sde_in;
    logic sd_in;
    logic sd_out;

    int tests = 0;
    int fails = 0;

    dmem_unit_if #(.DMEMSIZE(DMEMSIZE), .DATABITS(DATABITS)) bus ();

    dmem_unit #(.DMEMSIZE(DMEMSIZE), .DATABITS(DATABITS)) dut (
        .clk    (clk),
        .rst    (rst),
        .sde_in (sde_in),
        .sd_in  (sd_in),
        .sd_out (sd_out),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    // Advance to 1 time unit after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply(input logic [2:0] c, input logic [AW-1:0] a,
                         input logic [DATABITS-1:0] d, input logic [DATABITS-1:0] e);
        bus.cmd_in  = c;
        bus.addr_in = a;
        bus.d_in    = d;
        bus.ext_in  = e;
        tick();
        bus.cmd_in  = C_NOP;
    endtask

    task automatic read_word(input logic [AW-1:0] a, output logic [DATABITS-1:0] v);
        apply(C_READ, a, '0, '0);
        v = bus.d_out;
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    // Scan pattern word k.
    function automatic logic [DATABITS-1:0] pat(input int k);
        return 24'hA5C396 ^ 24'(32'(k) * 32'h000B1729);
    endfunction

    function automatic logic pbit(input int j);
        logic [DATABITS-1:0] w;
        w = pat(j / 24);
        return w[5'(j % 24)];
    endfunction

    task automatic test_reset();
        logic [DATABITS-1:0] v;
        int bad;
        sde_in = 1'b0; sd_in = 1'b0;
        bus.cmd_in = C_NOP; bus.addr_in = '0; bus.d_in = '0; bus.ext_in = '0;
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        tests++;
        if (bus.d_out !== 24'h0) begin
            fails++; $display("FAIL reset_dout: got %h expected %h", bus.d_out, 24'h0);
        end
        tests++;
        if (sd_out !== 1'b0) begin
            fails++; $display("FAIL reset_sd_out: got %b expected %b", sd_out, 1'b0);
        end
        for (int k = 0; k < int'(DMEMSIZE); k++) apply(C_WRITE, 4'(k), 24'hFFFFF0 | 24'(k), '0);
        tests++;
        if (sd_out !== 1'b1) begin
            fails++; $display("FAIL preload_sd_out: got %b expected %b", sd_out, 1'b1);
        end
        read_word(4'd5, v);
        tests++;
        if (v !== 24'hFFFFF5) begin
            fails++; $display("FAIL preload_read5: got %h expected %h", v, 24'hFFFFF5);
        end
        // Reset wins over a simultaneous WRITE.
        bus.cmd_in = C_WRITE; bus.addr_in = 4'd1; bus.d_in = 24'h111111;
        pulse_reset();
        bus.cmd_in = C_NOP;
        tests++;
        if (bus.d_out !== 24'h0 || sd_out !== 1'b0) begin
            fails++; $display("FAIL reset_outputs: got d_out=%h sd_out=%b expected 000000/0", bus.d_out, sd_out);
        end
        bad = 0;
        for (int k = 0; k < int'(DMEMSIZE); k++) begin
            read_word(4'(k), v);
            if (v !== 24'h0) bad++;
        end
        tests++;
        if (bad != 0) begin
            fails++; $display("FAIL reset_clear: got %0d nonzero words expected 0", bad);
        end
    endtask

    task automatic test_write_read();
        logic [DATABITS-1:0] v;
        int bad;
        apply(C_WRITE, 4'd3, 24'h123456, 24'h0);
        read_word(4'd3, v);
        tests++;
        if (v !== 24'h123456) begin
            fails++; $display("FAIL wr_rd3: got %h expected %h", v, 24'h123456);
        end
        bad = 0;
        for (int k = 0; k < int'(DMEMSIZE); k++) begin
            if (k != 3) begin
                read_word(4'(k), v);
                if (v !== 24'h0) bad++;
            end
        end
        tests++;
        if (bad != 0) begin
            fails++; $display("FAIL wr_others_zero: got %0d nonzero words expected 0", bad);
        end
        read_word(4'd3, v);
        repeat (3) apply(C_NOP, 4'd0, 24'hAAAAAA, 24'hBBBBBB);
        tests++;
        if (bus.d_out !== 24'h123456) begin
            fails++; $display("FAIL dout_hold_nop: got %h expected %h", bus.d_out, 24'h123456);
        end
        apply(C_WRITE, 4'd7, 24'hFEDCBA, 24'h0);
        tests++;
        if (bus.d_out !== 24'h123456) begin
            fails++; $display("FAIL dout_hold_write: got %h expected %h", bus.d_out, 24'h123456);
        end
        read_word(4'd7, v);
        tests++;
        if (v !== 24'hFEDCBA) begin
            fails++; $display("FAIL wr_rd7: got %h expected %h", v, 24'hFEDCBA);
        end
    endtask

    task automatic test_loadext();
        logic [DATABITS-1:0] v;
        apply(C_LOADEXT, 4'd15, 24'h555555, 24'hABCDEF);
        tests++;
        if (bus.d_out !== 24'hFEDCBA) begin
            fails++; $display("FAIL dout_hold_loadext: got %h expected %h", bus.d_out, 24'hFEDCBA);
        end
        read_word(4'd15, v);
        tests++;
        if (v !== 24'hABCDEF) begin
            fails++; $display("FAIL loadext_rd15: got %h expected %h", v, 24'hABCDEF);
        end
    endtask

    task automatic test_illegal_cmd();
        logic [DATABITS-1:0] v;
        apply(C_WRITE, 4'd2, 24'h0A0B0C, 24'h0);
        read_word(4'd2, v);
        for (int c = 5; c <= 7; c++) apply(3'(c), 4'd2, 24'hDEAD00, 24'hBEEF00);
        tests++;
        if (bus.d_out !== 24'h0A0B0C) begin
            fails++; $display("FAIL illegal_dout: got %h expected %h", bus.d_out, 24'h0A0B0C);
        end
        read_word(4'd2, v);
        tests++;
        if (v !== 24'h0A0B0C) begin
            fails++; $display("FAIL illegal_rd2: got %h expected %h", v, 24'h0A0B0C);
        end
        read_word(4'd0, v);
        tests++;
        if (v !== 24'h0) begin
            fails++; $display("FAIL illegal_rd0: got %h expected %h", v, 24'h0);
        end
        read_word(4'd3, v);
        tests++;
        if (v !== 24'h123456) begin
            fails++; $display("FAIL illegal_rd3: got %h expected %h", v, 24'h123456);
        end
    endtask

    task automatic test_shift();
        logic [DATABITS-1:0] v;
        logic [DATABITS-1:0] exp_v;
        int bad;
        pulse_reset();
        for (int i = 1; i <= 5; i++) apply(C_SHIFT, 4'(i * 3), 24'hF0F0F0, 24'(i));
        for (int k = 0; k < int'(DMEMSIZE); k++) begin
            read_word(4'(k), v);
            exp_v = (k < 5) ? 24'(5 - k) : 24'h0;
            tests++;
            if (v !== exp_v) begin
                fails++; $display("FAIL shift5_word%0d: got %h expected %h", k, v, exp_v);
            end
        end
        repeat (11) apply(C_SHIFT, 4'd0, 24'h0, 24'h0);
        read_word(4'd15, v);
        tests++;
        if (v !== 24'h1) begin
            fails++; $display("FAIL shift16_top: got %h expected %h", v, 24'h1);
        end
        repeat (5) apply(C_SHIFT, 4'd0, 24'h0, 24'h0);
        bad = 0;
        for (int k = 0; k < int'(DMEMSIZE); k++) begin
            read_word(4'(k), v);
            if (v !== 24'h0) bad++;
        end
        tests++;
        if (bad != 0) begin
            fails++; $display("FAIL shift_flush: got %0d nonzero words expected 0", bad);
        end
    endtask

    task automatic test_scan();
        logic [DATABITS-1:0] v;
        logic [DATABITS-1:0] w0;
        logic old_b;
        int bad;
        pulse_reset();
        w0 = 24'h777777;
        apply(C_WRITE, 4'd0, w0, 24'h0);
        read_word(4'd0, v);
        // Load pattern MSB-first; the old chain (only word 0 set) streams out.
        sde_in = 1'b1;
        bus.cmd_in = C_WRITE; bus.addr_in = 4'd0; bus.d_in = 24'hFFFFFF; bus.ext_in = 24'hFFFFFF;
        bad = 0;
        for (int i = 0; i < int'(CHAIN); i++) begin
            sd_in = pbit(int'(CHAIN) - 1 - i);
            old_b = (int'(CHAIN) - 1 - i < 24) ? w0[5'(int'(CHAIN) - 1 - i)] : 1'b0;
            if (sd_out !== old_b) bad++;
            tick();
        end
        tests++;
        if (bad != 0) begin
            fails++; $display("FAIL scan_unload_old: got %0d bit errors expected 0", bad);
        end
        tests++;
        if (bus.d_out !== w0) begin
            fails++; $display("FAIL scan_dout_hold: got %h expected %h", bus.d_out, w0);
        end
        bus.cmd_in = C_NOP;
        sde_in = 1'b0;
        bad = 0;
        for (int k = 0; k < int'(DMEMSIZE); k++) begin
            read_word(4'(k), v);
            if (v !== pat(k)) bad++;
        end
        tests++;
        if (bad != 0) begin
            fails++; $display("FAIL scan_load: got %0d wrong words expected 0", bad);
        end
        sde_in = 1'b1;
        sd_in = 1'b0;
        bad = 0;
        for (int i = 0; i < int'(CHAIN); i++) begin
            if (sd_out !== pbit(int'(CHAIN) - 1 - i)) bad++;
            tick();
        end
        sde_in = 1'b0;
        tests++;
        if (bad != 0) begin
            fails++; $display("FAIL scan_unload_pat: got %0d bit errors expected 0", bad);
        end
        bad = 0;
        for (int k = 0; k < int'(DMEMSIZE); k++) begin
            read_word(4'(k), v);
            if (v !== 24'h0) bad++;
        end
        tests++;
        if (bad != 0) begin
            fails++; $display("FAIL scan_zero_fill: got %0d nonzero words expected 0", bad);
        end
    endtask

    task automatic test_reset_mid_scan();
        logic [DATABITS-1:0] v;
        int bad;
        for (int k = 0; k < int'(DMEMSIZE); k++) apply(C_WRITE, 4'(k), 24'hFFFFFF, '0);
        sde_in = 1'b1;
        sd_in = 1'b0;
        repeat (100) tick();
        tests++;
        if (sd_out !== 1'b1) begin
            fails++; $display("FAIL midscan_sd_out: got %b expected %b", sd_out, 1'b1);
        end
        pulse_reset();
        tests++;
        if (sd_out !== 1'b0) begin
            fails++; $display("FAIL midscan_reset_sd_out: got %b expected %b", sd_out, 1'b0);
        end
        sde_in = 1'b0;
        bad = 0;
        for (int k = 0; k < int'(DMEMSIZE); k++) begin
            read_word(4'(k), v);
            if (v !== 24'h0) bad++;
        end
        tests++;
        if (bad != 0) begin
            fails++; $display("FAIL midscan_clear: got %0d nonzero words expected 0", bad);
        end
        apply(C_WRITE, 4'd9, 24'h13579B, 24'h0);
        read_word(4'd9, v);
        tests++;
        if (v !== 24'h13579B) begin
            fails++; $display("FAIL midscan_resume: got %h expected %h", v, 24'h13579B);
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_loadext();
        test_illegal_cmd();
        test_shift();
        test_scan();
        test_reset_mid_scan();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL timeout: got no completion expected finish before 1000000");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/dmem_unit.md
Name: dmem_unit

Overview:
- Data memory of the filter datapath: DMEMSIZE words of DATABITS bits, held in flip-flops.
- Controlled by a per-cycle command from the filter controller: read, write from datapath, load from external input, or delay-line shift.
- Includes a serial scan chain through all memory bits, for test load and unload.
- Sits between the external sample input (ext_in), the datapath (d_in/d_out) and the controller (cmd_in/addr_in).

Parameters:
- DMEMSIZE, 16, number of memory words; any value >= 2.
- DATABITS, 24, word width in bits.
- Address width AW = $clog2(DMEMSIZE).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- sde_in  input  1  scan enable; 1 = scan shift mode.
- sd_in  input  1  scan serial data in.
- sd_out  output  1  scan serial data out.
- cmd_in  input  3  dmem_cmd_t command: NOP=0, READ=1, WRITE=2, LOADEXT=3, SHIFT=4; codes 5-7 behave as NOP.
- addr_in  input  AW  word address.
- d_in  input  DATABITS  write data from datapath.
- ext_in  input  DATABITS  external sample input.
- d_out  output  DATABITS  registered read data.

Behaviour:
- Interface: one clock (clk); synchronous, active-high reset (rst). Reset is sampled only at the rising clk edge.
- Reset (rst=1 at edge): all mem words = 0, d_out = 0. Reset overrides scan and commands.
- Scan mode (rst=0, sde_in=1): commands are ignored.
  - Memory shifts as one chain {mem[DMEMSIZE-1], ..., mem[0]}, one bit toward the MSB per cycle.
  - sd_in enters mem[0][0]; mem[k][DATABITS-1] moves into mem[k+1][0].
  - Chain length is DMEMSIZE*DATABITS bits.
  - d_out holds its value.
- sd_out = mem[DMEMSIZE-1][DATABITS-1] at all times, driven combinationally from the register. After reset it is 0.
- Functional mode (rst=0, sde_in=0), one command per cycle:
  - NOP: no change.
  - READ: d_out <= mem[addr_in]. Latency 1 cycle; d_out then holds until the next READ or reset.
  - WRITE: mem[addr_in] <= d_in.
  - LOADEXT: mem[addr_in] <= ext_in.
  - SHIFT (delay line): mem[i] <= mem[i-1] for i = 1..DMEMSIZE-1, mem[0] <= ext_in, and the old mem[DMEMSIZE-1] is discarded. addr_in is ignored.
- d_out changes only on READ or reset.
- Read-during-write cannot occur, since each cycle carries a single command. A READ immediately after a WRITE to the same address returns the new data.
- Address >= DMEMSIZE (non-power-of-2 sizes):
  - WRITE/LOADEXT are ignored.
  - READ loads d_out = 0.
- No arithmetic; data passes through bit-exact with no sign handling.

Test Plan:
- Reset: preload values, assert rst one cycle -> every word reads back 0 via READ, d_out=0, sd_out=0.
- Write/read: WRITE addr 3 with d_in=24'h123456, next cycle READ addr 3 -> d_out=24'h123456 one cycle after the READ. Other addresses remain 0; d_out holds through subsequent NOPs.
- LOADEXT: ext_in=24'hABCDEF, LOADEXT addr 15 -> READ 15 gives 24'hABCDEF; d_in is ignored.
- Delay line: SHIFT five times with ext_in = 1, 2, 3, 4, 5 -> mem[0..4] = 5, 4, 3, 2, 1 and mem[5..15] = 0. Sixteen further SHIFTs with ext_in=0 -> all words 0.
- Scan: sde_in=1, shift 384 bits with a known pattern while cmd_in=WRITE -> memory contents equal the pattern and commands have no effect. Shifting 384 more bits returns the original pattern MSB-first on sd_out.
- Reset mid-scan: after 100 scan cycles assert rst -> memory 0, sd_out=0. Releasing rst with sde_in=0 resumes normal READ/WRITE operation.
